// File: rtl/pad_mux_sw.sv
// pad_mux_sw: maps one of NUM_IPS cores onto NUM_PADS pads with a
// debounced select and a quiesce/release switch sequence.
// Ports: sys_clk_i/arst_n_i clock and async active-low reset;
// ip_sel_i raw select straps; ip_en_mask_i populated-core mask;
// ip_o_i/ip_oe_i per-core pad data/enables, core k at [k*NUM_PADS +: NUM_PADS];
// pad_i raw pad inputs; pad_o/pad_oe registered pad drive;
// ip_in_o gated synchronised pad inputs; ip_rst_n_o per-core resets;
// active_sel_o/active_vld_o/switching_o status.
module pad_mux_sw #(
  parameter int NUM_PADS     = 82,
  parameter int NUM_IPS      = 8,
  parameter int SEL_W        = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4,
  parameter int QUIESCE_CYC  = 16
) (
  input  logic                        sys_clk_i,
  input  logic                        arst_n_i,
  input  logic [SEL_W-1:0]            ip_sel_i,
  input  logic [NUM_IPS-1:0]          ip_en_mask_i,
  input  logic [NUM_IPS*NUM_PADS-1:0] ip_o_i,
  input  logic [NUM_IPS*NUM_PADS-1:0] ip_oe_i,
  input  logic [NUM_PADS-1:0]         pad_i,
  output logic [NUM_PADS-1:0]         pad_o,
  output logic [NUM_PADS-1:0]         pad_oe,
  output logic [NUM_IPS*NUM_PADS-1:0] ip_in_o,
  output logic [NUM_IPS-1:0]          ip_rst_n_o,
  output logic [SEL_W-1:0]            active_sel_o,
  output logic                        active_vld_o,
  output logic                        switching_o
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int CW = $clog2(QUIESCE_CYC) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIESCE,
    S_RELEASE,
    S_RUN,
    S_PARK
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0][SEL_W-1:0]    sel_sync_q, sel_sync_d;
  logic [SYNC_STAGES-1:0][NUM_PADS-1:0] pad_sync_q, pad_sync_d;
  logic [SEL_W-1:0]   sel_sync;
  logic [NUM_PADS-1:0] pad_sync;
  logic [SEL_W-1:0]   sel_prev_q, sel_prev_d;
  logic [DW-1:0]      deb_cnt_q, deb_cnt_d;
  logic [SEL_W-1:0]   sel_stable_q, sel_stable_d;
  logic               stable_vld_q, stable_vld_d;
  logic [SEL_W-1:0]   target_q, target_d;
  logic [CW-1:0]      qcnt_q, qcnt_d;
  logic [SEL_W-1:0]   act_sel_q, act_sel_d;
  logic [NUM_IPS-1:0] rst_q, rst_d;
  logic [NUM_PADS-1:0] pad_o_q, pad_o_d;
  logic [NUM_PADS-1:0] pad_oe_q, pad_oe_d;
  logic [NUM_PADS-1:0] cur_o, cur_oe;
  logic               tgt_en, act_en, stb_en;

  // Out-of-range indices read as unpopulated.
  function automatic logic en_of(
    input logic [SEL_W-1:0]   idx,
    input logic [NUM_IPS-1:0] mask
  );
    logic r;
    r = 1'b0;
    for (int k = 0; k < NUM_IPS; k++) begin
      if (idx == SEL_W'(k)) r = mask[k];
    end
    return r;
  endfunction

  assign sel_sync = sel_sync_q[SYNC_STAGES-1];
  assign pad_sync = pad_sync_q[SYNC_STAGES-1];

  always_comb begin
    sel_sync_d[0] = ip_sel_i;
    pad_sync_d[0] = pad_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sel_sync_d[i] = sel_sync_q[i-1];
      pad_sync_d[i] = pad_sync_q[i-1];
    end
  end

  // deb_cnt counts consecutive identical synchronised samples.
  always_comb begin
    sel_prev_d   = sel_sync;
    sel_stable_d = sel_stable_q;
    stable_vld_d = stable_vld_q;
    if (sel_sync != sel_prev_q) begin
      deb_cnt_d = DW'(1);
    end else if (deb_cnt_q < DW'(DEBOUNCE_CYC)) begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end else begin
      deb_cnt_d = deb_cnt_q;
    end
    if (deb_cnt_d >= DW'(DEBOUNCE_CYC)) begin
      sel_stable_d = sel_sync;
      stable_vld_d = 1'b1;
    end
  end

  always_comb begin
    cur_o  = '0;
    cur_oe = '0;
    for (int k = 0; k < NUM_IPS; k++) begin
      if (act_sel_q == SEL_W'(k)) begin
        cur_o  = ip_o_i[k*NUM_PADS +: NUM_PADS];
        cur_oe = ip_oe_i[k*NUM_PADS +: NUM_PADS];
      end
    end
  end

  assign tgt_en = en_of(target_q, ip_en_mask_i);
  assign act_en = en_of(act_sel_q, ip_en_mask_i);
  assign stb_en = en_of(sel_stable_q, ip_en_mask_i);

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    qcnt_d    = qcnt_q;
    act_sel_d = act_sel_q;
    rst_d     = rst_q;
    pad_o_d   = '0;
    pad_oe_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (stable_vld_q) begin
          state_d  = S_QUIESCE;
          target_d = sel_stable_q;
          qcnt_d   = CW'(QUIESCE_CYC - 1);
        end
      end
      S_QUIESCE: begin
        rst_d = '0;
        if (sel_stable_q != target_q) begin
          target_d = sel_stable_q;
          qcnt_d   = CW'(QUIESCE_CYC - 1);
        end else if (qcnt_q == '0) begin
          if (tgt_en) begin
            state_d   = S_RELEASE;
            act_sel_d = target_q;
            rst_d     = NUM_IPS'(1) << target_q;
          end else begin
            state_d = S_PARK;
          end
        end else begin
          qcnt_d = qcnt_q - CW'(1);
        end
      end
      S_RELEASE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (sel_stable_q != act_sel_q || !act_en) begin
          state_d  = S_QUIESCE;
          target_d = sel_stable_q;
          qcnt_d   = CW'(QUIESCE_CYC - 1);
          rst_d    = '0;
        end else begin
          pad_o_d  = cur_o;
          pad_oe_d = cur_oe;
        end
      end
      S_PARK: begin
        rst_d = '0;
        if (sel_stable_q != target_q || stb_en) begin
          state_d  = S_QUIESCE;
          target_d = sel_stable_q;
          qcnt_d   = CW'(QUIESCE_CYC - 1);
        end
      end
      default: begin
        state_d = S_IDLE;
        rst_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q      <= S_IDLE;
      sel_sync_q   <= '0;
      pad_sync_q   <= '0;
      sel_prev_q   <= '0;
      deb_cnt_q    <= '0;
      sel_stable_q <= '0;
      stable_vld_q <= 1'b0;
      target_q     <= '0;
      qcnt_q       <= '0;
      act_sel_q    <= '0;
      rst_q        <= '0;
      pad_o_q      <= '0;
      pad_oe_q     <= '0;
    end else begin
      state_q      <= state_d;
      sel_sync_q   <= sel_sync_d;
      pad_sync_q   <= pad_sync_d;
      sel_prev_q   <= sel_prev_d;
      deb_cnt_q    <= deb_cnt_d;
      sel_stable_q <= sel_stable_d;
      stable_vld_q <= stable_vld_d;
      target_q     <= target_d;
      qcnt_q       <= qcnt_d;
      act_sel_q    <= act_sel_d;
      rst_q        <= rst_d;
      pad_o_q      <= pad_o_d;
      pad_oe_q     <= pad_oe_d;
    end
  end

  always_comb begin
    ip_in_o = '0;
    if (state_q == S_RUN) begin
      for (int k = 0; k < NUM_IPS; k++) begin
        if (act_sel_q == SEL_W'(k)) begin
          ip_in_o[k*NUM_PADS +: NUM_PADS] = pad_sync;
        end
      end
    end
  end

  assign pad_o        = pad_o_q;
  assign pad_oe       = pad_oe_q;
  assign ip_rst_n_o   = rst_q;
  assign active_sel_o = act_sel_q;
  assign active_vld_o = (state_q == S_RUN);
  assign switching_o  = (state_q == S_QUIESCE) || (state_q == S_RELEASE);

endmodule
